// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, frame width and the receiver state encoding.
package uart_pkg;
  localparam int BAUD_DIV_DEFAULT = 2604;  // 50 MHz / 19200
  localparam int DATA_BITS        = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver plus the serial line it listens to.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 RX;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 frm_err;
  logic                 ovr_err;

  modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr_err);
  modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin, plus a falling-edge detect on the clean copy.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic rx_s,
  output logic fall
);
  logic meta_q, sync_q, rx_s_q;

  // Reset to 1 so the line looks idle and no false edge appears out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= RX;
      sync_q <= meta_q;
      rx_s_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = rx_s_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a falling-edge-aligned baud counter, rdy/clr_rdy
// handshake, framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HALF_M1 = cnt_t'(HALF - 1);
  localparam cnt_t FULL_M1 = cnt_t'(BAUD_DIV - 1);

  logic                 rx_s, fall, tick;
  rx_state_t            state_q;
  cnt_t                 baud_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shft_q, data_q;
  logic                 rdy_q, frm_q, ovr_q;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .RX   (bus.RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign tick = (state_q != IDLE) && (baud_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shft_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (bus.clr_rdy) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      if (state_q != IDLE) baud_q <= tick ? FULL_M1 : baud_q - 1'b1;

      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          baud_q  <= HALF_M1;
        end
        // A start bit that is high again at its midpoint was a glitch; drop it quietly.
        START: if (tick) begin
          if (rx_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: if (tick) begin
          shft_q <= {rx_s, shft_q[DATA_BITS-1:1]};
          bit_q  <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        // Leave at mid-stop so a start bit right after the stop bit is still seen;
        // setting rdy here wins over a coincident clr_rdy.
        STOP: if (tick) begin
          data_q  <= shft_q;
          frm_q   <= ~rx_s;
          rdy_q   <= 1'b1;
          if (rdy_q && !bus.clr_rdy) ovr_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_q;
  assign bus.ovr_err = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (BAUD_DIV=16) for every scenario, a 2604 instance for one frame.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD       = 16;
  localparam int HALF     = BD / 2;
  localparam int BDS      = 2604;
  localparam int HALFS    = BDS / 2;
  localparam int TICK_CYC = 2 + HALF + 9 * BD;     // stop-tick cycle counted from start-bit drive
  localparam int TICK_S   = 2 + HALFS + 9 * BDS;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_if bus_f ();
  uart_rx_if bus_s ();

  uart_rx #(.BAUD_DIV(BD))  dut_f (.clk(clk), .rst(rst), .bus(bus_f));
  uart_rx #(.BAUD_DIV(BDS)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit slow, input logic v);
    if (slow) bus_s.RX = v;
    else      bus_f.RX = v;
  endtask

  task automatic send(input bit slow, input logic [7:0] b, input logic stopb);
    int bd;
    bd = slow ? BDS : BD;
    drive(slow, 1'b0);
    repeat (bd) tick();
    for (int i = 0; i < 8; i++) begin
      drive(slow, b[i]);
      repeat (bd) tick();
    end
    drive(slow, stopb);
    repeat (bd) tick();
    drive(slow, 1'b1);
  endtask

  task automatic clr_pulse();
    bus_f.clr_rdy = 1'b1;
    tick();
    bus_f.clr_rdy = 1'b0;
  endtask

  task automatic wait_rdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_f.rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_f.RX = 1'b1; bus_f.clr_rdy = 1'b0;
    bus_s.RX = 1'b1; bus_s.clr_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_run++; if (bus_f.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", bus_f.rdy); end
    n_run++; if (bus_f.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus_f.rx_data); end
    n_run++; if ({bus_f.frm_err, bus_f.ovr_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {bus_f.frm_err, bus_f.ovr_err}); end
    n_run++; if ({bus_s.rdy, bus_s.frm_err, bus_s.ovr_err} !== 3'b000) begin n_fail++; $display("FAIL reset_slow: got %b want 000", {bus_s.rdy, bus_s.frm_err, bus_s.ovr_err}); end
  endtask

  task automatic test_basic();
    fork
      send(1'b0, 8'hA5, 1'b1);
      begin
        repeat (TICK_CYC) tick();
        n_run++; if (bus_f.rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_early: got %b want 0", bus_f.rdy); end
        tick();
        n_run++; if (bus_f.rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_edge: got %b want 1", bus_f.rdy); end
        n_run++; if (bus_f.rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", bus_f.rx_data); end
        n_run++; if (bus_f.frm_err !== 1'b0) begin n_fail++; $display("FAIL basic_frm: got %b want 0", bus_f.frm_err); end
      end
    join
    clr_pulse();
    n_run++; if (bus_f.rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clr: got %b want 0", bus_f.rdy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fork
      begin
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'hFF, 1'b1);
      end
      begin
        wait_rdy(12 * BD, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout: got rdy %b want 1", bus_f.rdy); end
        n_run++; if ({bus_f.rx_data, bus_f.frm_err} !== 9'h000) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 00/0", bus_f.rx_data, bus_f.frm_err); end
        clr_pulse();
        wait_rdy(12 * BD, ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: got rdy %b want 1", bus_f.rdy); end
        n_run++; if (bus_f.rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data: got %h want ff", bus_f.rx_data); end
        n_run++; if ({bus_f.frm_err, bus_f.ovr_err} !== 2'b00) begin n_fail++; $display("FAIL b2b_errs: got %b want 00", {bus_f.frm_err, bus_f.ovr_err}); end
        clr_pulse();
      end
    join
  endtask

  task automatic test_false_start();
    drive(1'b0, 1'b0);
    repeat (HALF - 2) tick();
    drive(1'b0, 1'b1);
    repeat (12 * BD) tick();
    n_run++; if ({bus_f.rdy, bus_f.frm_err, bus_f.ovr_err} !== 3'b000) begin n_fail++; $display("FAIL false_start: got %b want 000", {bus_f.rdy, bus_f.frm_err, bus_f.ovr_err}); end
  endtask

  task automatic test_framing();
    send(1'b0, 8'h3C, 1'b0);
    n_run++; if ({bus_f.rdy, bus_f.frm_err} !== 2'b11) begin n_fail++; $display("FAIL frm_flags: got %b want 11", {bus_f.rdy, bus_f.frm_err}); end
    n_run++; if (bus_f.rx_data !== 8'h3C) begin n_fail++; $display("FAIL frm_data: got %h want 3c", bus_f.rx_data); end
    clr_pulse();
    send(1'b0, 8'hC3, 1'b1);
    n_run++; if ({bus_f.rdy, bus_f.frm_err} !== 2'b10) begin n_fail++; $display("FAIL frm_recover: got %b want 10", {bus_f.rdy, bus_f.frm_err}); end
    n_run++; if (bus_f.rx_data !== 8'hC3) begin n_fail++; $display("FAIL frm_recover_data: got %h want c3", bus_f.rx_data); end
    clr_pulse();
  endtask

  task automatic test_overrun();
    send(1'b0, 8'h11, 1'b1);
    send(1'b0, 8'h22, 1'b1);
    n_run++; if (bus_f.rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h want 22", bus_f.rx_data); end
    n_run++; if ({bus_f.rdy, bus_f.ovr_err} !== 2'b11) begin n_fail++; $display("FAIL ovr_flags: got %b want 11", {bus_f.rdy, bus_f.ovr_err}); end
    clr_pulse();
    n_run++; if ({bus_f.rdy, bus_f.ovr_err} !== 2'b00) begin n_fail++; $display("FAIL ovr_clr: got %b want 00", {bus_f.rdy, bus_f.ovr_err}); end
    send(1'b0, 8'h33, 1'b1);
    n_run++; if ({bus_f.rdy, bus_f.rx_data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL ovr_pre: got %b/%h want 1/33", bus_f.rdy, bus_f.rx_data); end
    fork
      send(1'b0, 8'h44, 1'b1);
      begin
        repeat (TICK_CYC) tick();
        clr_pulse();
      end
    join
    n_run++; if ({bus_f.rdy, bus_f.ovr_err} !== 2'b10) begin n_fail++; $display("FAIL ovr_coincident: got %b want 10", {bus_f.rdy, bus_f.ovr_err}); end
    n_run++; if (bus_f.rx_data !== 8'h44) begin n_fail++; $display("FAIL ovr_coincident_data: got %h want 44", bus_f.rx_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h5A;
    drive(1'b0, 1'b0);
    repeat (BD) tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, b[i]);
      repeat (BD) tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b1);
    tick();
    rst = 1'b0;
    n_run++; if ({bus_f.rdy, bus_f.frm_err, bus_f.ovr_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {bus_f.rdy, bus_f.frm_err, bus_f.ovr_err}); end
    n_run++; if (bus_f.rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", bus_f.rx_data); end
    repeat (2 * BD) tick();
    send(1'b0, 8'h96, 1'b1);
    n_run++; if ({bus_f.rdy, bus_f.frm_err, bus_f.ovr_err} !== 3'b100) begin n_fail++; $display("FAIL rstmid_next_flags: got %b want 100", {bus_f.rdy, bus_f.frm_err, bus_f.ovr_err}); end
    n_run++; if (bus_f.rx_data !== 8'h96) begin n_fail++; $display("FAIL rstmid_next_data: got %h want 96", bus_f.rx_data); end
    clr_pulse();
  endtask

  task automatic test_break();
    drive(1'b0, 1'b0);
    repeat (12 * BD) tick();
    n_run++; if ({bus_f.rdy, bus_f.frm_err} !== 2'b11) begin n_fail++; $display("FAIL break_flags: got %b want 11", {bus_f.rdy, bus_f.frm_err}); end
    n_run++; if (bus_f.rx_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h want 00", bus_f.rx_data); end
    clr_pulse();
    repeat (12 * BD) tick();
    n_run++; if (bus_f.rdy !== 1'b0) begin n_fail++; $display("FAIL break_retrigger: got %b want 0", bus_f.rdy); end
    drive(1'b0, 1'b1);
    repeat (2 * BD) tick();
    send(1'b0, 8'h81, 1'b1);
    n_run++; if ({bus_f.rdy, bus_f.frm_err, bus_f.rx_data} !== {2'b10, 8'h81}) begin n_fail++; $display("FAIL break_after: got %b/%b/%h want 1/0/81", bus_f.rdy, bus_f.frm_err, bus_f.rx_data); end
    clr_pulse();
  endtask

  task automatic test_slow_baud();
    fork
      send(1'b1, 8'hA5, 1'b1);
      begin
        repeat (TICK_S) tick();
        n_run++; if (bus_s.rdy !== 1'b0) begin n_fail++; $display("FAIL slow_rdy_early: got %b want 0", bus_s.rdy); end
        tick();
        n_run++; if ({bus_s.rdy, bus_s.frm_err} !== 2'b10) begin n_fail++; $display("FAIL slow_flags: got %b want 10", {bus_s.rdy, bus_s.frm_err}); end
        n_run++; if (bus_s.rx_data !== 8'hA5) begin n_fail++; $display("FAIL slow_data: got %h want a5", bus_s.rx_data); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_false_start();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_break();
    test_slow_baud();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
